// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock, N iterations,
// then a registered one-cycle done pulse alongside the 2N-bit product.
module seq_multiplier #(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] LastCount = CW'(N - 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]     state;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mult;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  count;

    logic [2*N-1:0] addend;
    logic [2*N-1:0] sum;

    always_comb begin
        addend = mult[0] ? mcand : '0;
        sum    = acc + addend;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= StIdle;
            mcand   <= '0;
            mult    <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the completion edge re-asserts it
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        mcand <= {{N{1'b0}}, a};
                        mult  <= b;
                        acc   <= '0;
                        count <= '0;
                        state <= StRun;
                    end
                end
                StRun: begin
                    acc   <= sum;
                    mcand <= mcand << 1;
                    mult  <= mult >> 1;
                    count <= count + CW'(1);
                    if (count == LastCount) begin
                        product <= sum;
                        done    <= 1'b1;
                        state   <= StIdle;
                    end
                end
            endcase
        end
    end

    assign busy = (state == StRun);

endmodule
